load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_store_unit_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, FSM encoding and decode helpers for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!st)
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3,
                                         input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU))
      bad = a[0];
    else if (f3 == F3_W)
      bad = |a;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
// Halfword lanes use offset bit 1 only; words ignore the offset entirely.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_old[7:0];
    unique case (i_off)
      2'd1:    w_byte = i_old[15:8];
      2'd2:    w_byte = i_old[23:16];
      2'd3:    w_byte = i_old[31:24];
      default: w_byte = i_old[7:0];
    endcase
    w_half = i_off[1] ? i_old[31:16] : i_old[15:0];
  end

  always_comb begin
    o_load = i_old;
    unique case (i_f3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_old;
    endcase
  end

  always_comb begin
    o_store = i_wdata;
    unique case (i_f3)
      F3_B: begin
        o_store = i_old;
        unique case (i_off)
          2'd1:    o_store[15:8]  = i_wdata[7:0];
          2'd2:    o_store[23:16] = i_wdata[7:0];
          2'd3:    o_store[31:24] = i_wdata[7:0];
          default: o_store[7:0]   = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        o_store = i_old;
        if (i_off[1])
          o_store[31:16] = i_wdata[15:0];
        else
          o_store[15:0]  = i_wdata[15:0];
      end
      default: o_store = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store FSM with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into errors.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        STORE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic [31:0] MEM_A,
  output logic        MEM_WE,
  output logic [31:0] MEM_WD,
  input  logic [31:0] MEM_RD
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic [31:0] r_wdata;
  logic        r_store;
  logic [31:0] r_old;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_bad;
  logic        w_take;
  logic [31:0] w_old;
  logic [31:0] w_load;
  logic [31:0] w_wd;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_bad = !f3_legal(STORE, FUNCT3) ||
                 f3_misaligned(FUNCT3, ADDR[1:0]);
`else
  assign w_bad = !f3_legal(STORE, FUNCT3);
`endif

  assign w_take = (r_state == S_IDLE) && REQ;

  // Loads extract straight from the live read; stores merge the saved word.
  assign w_old = (r_state == S_WRITE) ? r_old : MEM_RD;

  lsu_align u_align (
    .i_old   (w_old),
    .i_off   (r_addr[1:0]),
    .i_f3    (r_f3),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_store (w_wd)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (REQ) begin
          if (w_bad)
            w_next = S_RESP;
          else if (STORE && (FUNCT3 == F3_W))
            w_next = S_WRITE;
          else
            w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = r_store ? S_WRITE : S_RESP;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_f3    <= '0;
      r_wdata <= '0;
      r_store <= 1'b0;
      r_old   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_addr  <= ADDR;
        r_f3    <= FUNCT3;
        r_wdata <= WDATA;
        r_store <= STORE;
        r_err   <= w_bad;
        if (w_bad || STORE)
          r_rdata <= '0;
      end
      if (r_state == S_ACCESS) begin
        r_old <= MEM_RD;
        if (!r_store)
          r_rdata <= w_load;
      end
    end
  end

  assign BUSY   = (r_state != S_IDLE);
  assign DONE   = (r_state == S_RESP);
  assign ERR    = r_err;
  assign RDATA  = r_rdata;
  assign MEM_A  = {r_addr[31:2], 2'b00};
  assign MEM_WE = (r_state == S_WRITE);
  assign MEM_WD = (r_state == S_WRITE) ? w_wd : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        CLK;
  logic        RST;
  logic        REQ;
  logic        STORE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [31:0] RDATA;
  logic [31:0] MEM_A;
  logic        MEM_WE;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .STORE  (STORE),
    .FUNCT3 (FUNCT3),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR),
    .RDATA  (RDATA),
    .MEM_A  (MEM_A),
    .MEM_WE (MEM_WE),
    .MEM_WD (MEM_WD),
    .MEM_RD (MEM_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign MEM_RD = mem[MEM_A[7:2]];

  always @(posedge CLK)
    if (MEM_WE)
      mem[MEM_A[7:2]] <= MEM_WD;

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          we;
    logic [31:0] mwd;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err,
                       output int lat, output int we,
                       output logic [31:0] mwd);
    bit seen;
    @(negedge CLK);
    REQ = 1'b1; STORE = st; FUNCT3 = f3; ADDR = a; WDATA = wd;
    @(posedge CLK);
    #1;
    REQ = 1'b0;
    lat = 0; we = 0; mwd = '0; rd = '0; err = 1'b0; seen = 0;
    while (!seen && lat < 10) begin
      @(negedge CLK);
      lat++;
      if (MEM_WE) begin
        we++;
        mwd = MEM_WD;
      end
      if (DONE) begin
        seen = 1;
        rd = RDATA;
        err = ERR;
      end
    end
    if (!seen) lat = 99;
  endtask

  initial begin
    logic [31:0] rd, mwd;
    logic        err;
    int          lat, we, dn;
    bit          we_seen;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8899AABB;
    mem[12] = 32'h11223344;

    v[0]  = '{"LB13",  0, 3'b000, 32'h13, 0, 32'hFFFFFF88, 0, 2, 0, 0};
    v[1]  = '{"LBU11", 0, 3'b100, 32'h11, 0, 32'h000000AA, 0, 2, 0, 0};
    v[2]  = '{"LH12",  0, 3'b001, 32'h12, 0, 32'hFFFF8899, 0, 2, 0, 0};
    v[3]  = '{"LHU10", 0, 3'b101, 32'h10, 0, 32'h0000AABB, 0, 2, 0, 0};
    v[4]  = '{"LW10",  0, 3'b010, 32'h10, 0, 32'h8899AABB, 0, 2, 0, 0};
    v[5]  = '{"SB11",  1, 3'b000, 32'h11, 32'h12345655, 0, 0, 3, 1,
              32'h889955BB};
    v[6]  = '{"LW10b", 0, 3'b010, 32'h10, 0, 32'h889955BB, 0, 2, 0, 0};
    v[7]  = '{"SW20",  1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 0, 2, 1,
              32'hDEADBEEF};
    v[8]  = '{"LW20",  0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 2, 0, 0};
    v[9]  = '{"ILLLD", 0, 3'b011, 32'h10, 0, 0, 1, 1, 0, 0};
    v[10] = '{"ILLST", 1, 3'b100, 32'h10, 32'h1, 0, 1, 1, 0, 0};
    v[11] = '{"SH22",  1, 3'b001, 32'h22, 32'h0000CAFE, 0, 0, 3, 1,
              32'hCAFEBEEF};
    v[12] = '{"LB20",  0, 3'b000, 32'h20, 0, 32'hFFFFFFEF, 0, 2, 0, 0};
    v[13] = '{"LH22",  0, 3'b001, 32'h22, 0, 32'hFFFFCAFE, 0, 2, 0, 0};
`ifdef LSU_MISALIGN_TRAP_EN
    v[14] = '{"LW12",  0, 3'b010, 32'h12, 0, 0, 1, 1, 0, 0};
    v[15] = '{"LH11",  0, 3'b001, 32'h11, 0, 0, 1, 1, 0, 0};
`else
    v[14] = '{"LW12",  0, 3'b010, 32'h12, 0, 32'h889955BB, 0, 2, 0, 0};
    v[15] = '{"LH11",  0, 3'b001, 32'h11, 0, 32'h000055BB, 0, 2, 0, 0};
`endif

    RST = 1'b1; REQ = 1'b0; STORE = 1'b0; FUNCT3 = '0;
    ADDR = '0; WDATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_done", {31'd0, DONE}, 0);
    chk("rst_err", {31'd0, ERR}, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_mema", MEM_A, 0);
    chk("rst_we", {31'd0, MEM_WE}, 0);
    chk("rst_wd", MEM_WD, 0);
    RST = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op(v[i].st, v[i].f3, v[i].a, v[i].wd, rd, err, lat, we, mwd);
      chk({v[i].name, "_rdata"}, rd, v[i].rd);
      chk({v[i].name, "_err"}, {31'd0, err}, {31'd0, v[i].err});
      chk({v[i].name, "_lat"}, lat, v[i].lat);
      chk({v[i].name, "_we"}, we, v[i].we);
      if (v[i].we == 1)
        chk({v[i].name, "_mwd"}, mwd, v[i].mwd);
    end

    // Final memory contents after the store vectors
    chk("mem10", mem[4], 32'h889955BB);
    chk("mem20", mem[8], 32'hCAFEBEEF);

    // Abort an SH in its WRITE cycle
    @(negedge CLK);
    REQ = 1'b1; STORE = 1'b1; FUNCT3 = 3'b001;
    ADDR = 32'h30; WDATA = 32'h0000FFFF;
    @(posedge CLK);
    #1;
    REQ = 1'b0;
    we_seen = 0;
    for (int k = 0; k < 5 && !we_seen; k++) begin
      @(negedge CLK);
      if (MEM_WE) we_seen = 1;
    end
    chk("abort_we_seen", {31'd0, we_seen}, 1);
    RST = 1'b1;
    #1;
    chk("abort_we_drop", {31'd0, MEM_WE}, 0);
    chk("abort_busy_rst", {31'd0, BUSY}, 0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_busy", {31'd0, BUSY}, 0);
    chk("abort_mem", mem[12], 32'h11223344);

    // Unit still works after the abort
    do_op(1'b0, 3'b010, 32'h30, 32'h0, rd, err, lat, we, mwd);
    chk("post_lw30", rd, 32'h11223344);
    chk("post_lat", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
